// File: rtl/literal_pack_pkg.sv
// Shared types and the literal classification helper
// for the literal word packer.
package literal_pack_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HALF,
      FLUSH_PEND
   } state_e;

   localparam logic [7:0]  CLS_ZERO = 8'h00;
   localparam logic [7:0]  CLS_ONES = 8'hFF;
   localparam logic [7:0]  CLS_LO   = 8'h10;
   localparam logic [7:0]  CLS_HI   = 8'h20;
   localparam logic [15:0] PAD_WORD = 16'h0000;

   function automatic logic [1:0] lit_tag(
      input logic [15:0] first,
      input logic [15:0] second,
      input logic [15:0] match
   );
      logic [1:0] t;
      t[0] = (first == match) || (second == match);
      t[1] = first[15:8] inside {CLS_ZERO, CLS_ONES, [CLS_LO:CLS_HI]};
      return t;
   endfunction

endpackage

// File: rtl/literal_pack_fifo.sv
// Synchronous FIFO holding tagged packed entries; head is
// presented combinationally from the read pointer.
module literal_pack_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [WIDTH-1:0]           head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign push_ok = push_i && (count_q != FULL_C);
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/literal_word_packer.sv
// Packs pairs of 16-bit literal words into tagged 32-bit
// entries and counts occurrences of the match literal.
module literal_word_packer
   import literal_pack_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] MATCH_WORD = 16'h1234
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_word,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_tag,
   output logic [7:0]  match_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

   state_e        state_q, state_d;
   logic [15:0]   hold_q, hold_d;
   logic [7:0]    match_q, match_d;
   logic          push;
   logic [33:0]   push_data;
   logic [33:0]   head;
   logic [CW-1:0] count;
   logic          full;
   logic          accept;

   assign full   = (count == FULL_C);
   assign accept = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      in_ready  = 1'b0;
      push      = 1'b0;
      push_data = '0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_d  = in_word;
               state_d = HALF;
            end
         end
         HALF: begin
            in_ready = !full;
            if (in_valid && !full) begin
               push      = 1'b1;
               push_data = {lit_tag(hold_q, in_word, MATCH_WORD),
                            hold_q, in_word};
               hold_d    = '0;
               state_d   = IDLE;
            end else if (flush) begin
               state_d = FLUSH_PEND;
               if (!full) begin
                  push      = 1'b1;
                  // Second arg repeats first so padding never sets bit0
                  push_data = {lit_tag(hold_q, hold_q, MATCH_WORD),
                               hold_q, PAD_WORD};
                  hold_d    = '0;
                  state_d   = IDLE;
               end
            end
         end
         FLUSH_PEND: begin
            if (!full) begin
               push      = 1'b1;
               push_data = {lit_tag(hold_q, hold_q, MATCH_WORD),
                            hold_q, PAD_WORD};
               hold_d    = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      match_d = match_q;
      if (accept && (in_word == MATCH_WORD) && (match_q != 8'hFF)) begin
         match_d = match_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         match_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         match_q <= match_d;
      end
   end

   literal_pack_fifo #(
      .WIDTH (34),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (out_ready),
      .count_o     (count),
      .head_o      (head)
   );

   assign out_valid   = (count != '0);
   assign out_data    = head[31:0];
   assign out_tag     = head[33:32];
   assign match_count = match_q;

endmodule

// File: tb/tb_literal_word_packer.sv
// Scoreboard bench for literal_word_packer: directed words in,
// monitor compares every popped entry against the queue.
module tb_literal_word_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_word = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic [7:0]  match_count;

   int n_chk  = 0;
   int n_fail = 0;

   logic [33:0] exp_q[$];
   logic [33:0] mon_e;

   literal_word_packer #(
      .FIFO_DEPTH (4),
      .MATCH_WORD (16'h1234)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word     (in_word),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [33:0] act,
                        input logic [33:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_entry: got %h tag %b expected none",
                     out_data, out_tag);
         end else begin
            mon_e = exp_q.pop_front();
            check("entry_data", {2'b0, out_data}, {2'b0, mon_e[31:0]});
            check("entry_tag", {32'b0, out_tag}, {32'b0, mon_e[33:32]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      int t = 0;
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: word %h in_ready %b required 1",
                  w, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] tag);
      exp_q.push_back({tag, a, b});
      send(a);
      send(b);
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 400) begin
         step();
         t++;
      end
      step();
      @(negedge clk);
      check("drain_queue_empty", 34'(exp_q.size()), 34'd0);
      check("drain_out_valid", {33'b0, out_valid}, 34'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", {33'b0, in_ready}, 34'd1);
      check("rst_out_valid", {33'b0, out_valid}, 34'd0);
      check("rst_out_data", {2'b0, out_data}, 34'd0);
      check("rst_out_tag", {32'b0, out_tag}, 34'd0);
      check("rst_match_count", {26'b0, match_count}, 34'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic pair with match in second half
      out_ready = 1'b0;
      send_pair(16'hAB00, 16'h1234, 2'b01);
      check("latency_out_valid", {33'b0, out_valid}, 34'd1);
      drain();
      check("mc_after_pair", {26'b0, match_count}, 34'd1);

      // Class tag plus flush of a held half
      send_pair(16'h1500, 16'hDEAD, 2'b10);
      exp_q.push_back({2'b10, 16'hFF01, 16'h0000});
      send(16'hFF01);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drain();
      check("mc_after_flush", {26'b0, match_count}, 34'd1);

      // Fill FIFO, then back-pressure in HALF
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_pair(16'h3000 + 16'(2 * i), 16'h3001 + 16'(2 * i), 2'b00);
      end
      exp_q.push_back({2'b00, 16'h3008, 16'h3009});
      send(16'h3008);
      in_valid = 1'b1;
      in_word  = 16'h3009;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_half_in_ready", {33'b0, in_ready}, 34'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("no_passthrough", {33'b0, in_ready}, 34'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("slot_freed_in_ready", {33'b0, in_ready}, 34'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;

      // Flush while full -> FLUSH_PEND until a slot frees
      send(16'h300A);
      exp_q.push_back({2'b00, 16'h300A, 16'h0000});
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_pend_in_ready", {33'b0, in_ready}, 34'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_pend_popcyc", {33'b0, in_ready}, 34'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("flush_pend_postpop", {33'b0, in_ready}, 34'd0);
      @(negedge clk);
      check("flush_done_idle", {33'b0, in_ready}, 34'd1);
      @(posedge clk);
      #1;
      drain();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      @(negedge clk);
      check("idle_flush_ignored", {33'b0, out_valid}, 34'd0);
      @(posedge clk);
      #1;

      // Saturating match counter; 8'h12 lies in the class range
      out_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send_pair(16'h1234, 16'h1234, 2'b11);
      end
      drain();
      check("mc_saturated", {26'b0, match_count}, 34'hFF);

      // Reset with queued entries and a held half
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(16'h1234);
      end
      send(16'h5555);
      check("pre_rst_out_valid", {33'b0, out_valid}, 34'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {33'b0, out_valid}, 34'd0);
      check("arst_match_count", {26'b0, match_count}, 34'd0);
      check("arst_in_ready", {33'b0, in_ready}, 34'd1);
      check("arst_out_data", {2'b0, out_data}, 34'd0);
      check("arst_out_tag", {32'b0, out_tag}, 34'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send_pair(16'h4321, 16'h0000, 2'b00);
      drain();
      check("mc_after_reset", {26'b0, match_count}, 34'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
